// File: rtl/conv_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_frame_loader: collects a raster pixel stream into a frame buffer,   |
// | launches the convolver and holds the frame until it reports done.        |
// | Option: LOADER_DBUF_EN selects ping-pong buffering.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module conv_frame_loader #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  input  logic signed [DW-1:0]      pix_data,
  output logic                      pix_ready,
  output logic [IMG_H*IMG_W*DW-1:0] frame_out,
  output logic                      in_st,
  input  logic                      conv_done,
  output logic                      busy,
  output logic                      sof_err,
  output logic [7:0]                frame_cnt
);
  localparam int N  = IMG_H * IMG_W;
  localparam int IW = $clog2(N);
`ifdef LOADER_DBUF_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int AW = $clog2(BANKS * N);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, wr_idx;
  logic          armed, accept, resync, last, launch_go;
  logic          fill_bank, show_bank;
  logic [AW-1:0] wr_addr, rd_base;
  logic [DW-1:0] mem [BANKS*N];

  // Raster position is kept as one linear index; an early SOF forces it back to 0.
  assign pix_ready = armed && (state == FILL);
  assign accept    = pix_valid && pix_ready;
  assign resync    = pix_sof && (idx != '0);
  assign wr_idx    = resync ? '0 : idx;
  assign last      = (wr_idx == IW'(N - 1));
  assign in_st     = (state == LAUNCH);
  assign wr_addr   = AW'(wr_idx) + (fill_bank ? AW'(N) : '0);
  assign rd_base   = show_bank ? AW'(N) : '0;

`ifdef LOADER_DBUF_EN
  logic busy_q;

  // A finished bank launches at once if the convolver is free (or frees this cycle).
  assign launch_go = ((state == FILL) && accept && last && (!busy_q || conv_done))
                   || ((state == HOLD) && conv_done);
  assign busy      = busy_q || (state == LAUNCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_bank <= 1'b0;
      show_bank <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (launch_go) begin
        show_bank <= fill_bank;
        fill_bank <= ~fill_bank;
      end
      if (state == LAUNCH)
        busy_q <= 1'b1;
      else if (conv_done && !launch_go)
        busy_q <= 1'b0;
    end
  end
`else
  assign fill_bank = 1'b0;
  assign show_bank = 1'b0;
  assign launch_go = (state == FILL) && accept && last;
  assign busy      = (state == LAUNCH) || (state == WAIT);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      FILL:   if (accept && last) state_nx = launch_go ? LAUNCH : HOLD;
`ifdef LOADER_DBUF_EN
      LAUNCH: state_nx = FILL;
`else
      LAUNCH: state_nx = WAIT;
`endif
      WAIT:   if (conv_done) state_nx = FILL;
      HOLD:   if (conv_done) state_nx = LAUNCH;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      idx       <= '0;
      armed     <= 1'b0;
      sof_err   <= 1'b0;
      frame_cnt <= 8'd0;
      for (int i = 0; i < BANKS * N; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (state == LAUNCH) frame_cnt <= frame_cnt + 8'd1;
      if (accept) begin
        mem[wr_addr] <= pix_data;
        idx          <= last ? '0 : wr_idx + IW'(1);
        if (resync || (!pix_sof && (idx == '0))) sof_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign frame_out[i*DW +: DW] = mem[rd_base + AW'(i)];
  end

endmodule
`default_nettype wire
